// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types and helpers for the store-and-forward AXI-Stream packet FIFO.
package axis_pkt_fifo_pkg;

    // Write-side machine: FILL stores beats, DROP discards an oversize packet
    typedef enum logic [0:0] {
        WR_FILL = 1'b0,
        WR_DROP = 1'b1
    } wr_state_e;

    // Pointers carry one extra wrap bit so that full and empty can be told apart
    function automatic int ptr_width(input int lgfifo);
        return lgfifo + 32'sd1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_mem.sv
// Simple dual-port beat RAM: one write port and one registered read port.
// The read register doubles as the FIFO output stage. It holds its value
// while rd_en is low and clears to zero on reset.
module axis_pkt_fifo_mem #(
    parameter int AW = 32'sd5,
    parameter int W  = 32'sd38
) (
    input  logic          i_aclk,
    input  logic          i_aresetn,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    localparam int DEPTH_C = 32'sd1 << AW;

    logic [W-1:0] mem_r [DEPTH_C];
    logic [W-1:0] rd_data_r;

    // Beat storage write port
    always_ff @(posedge i_aclk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port, held while the downstream stage is stalled
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            rd_data_r <= {W{1'b0}};
        end else if (rd_en) begin
            rd_data_r <= mem_r[rd_addr];
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/axis_pkt_fifo.sv
// Store-and-forward AXI-Stream packet FIFO.
// A packet becomes visible to the M side only after its TLAST beat is stored.
// A packet that cannot fit in an otherwise empty FIFO is discarded, and
// o_overflow pulses once for it.
// Optional build macro AXIS_PKT_FIFO_DROP_EN: when defined, a packet whose
// TLAST beat has TUSER[0] set is discarded silently instead of committed.
module axis_pkt_fifo
    import axis_pkt_fifo_pkg::*;
#(
    parameter int C_AXIS_DATA_WIDTH = 32'sd32,
    parameter int C_AXIS_USER_WIDTH = 32'sd1,
    parameter int LGFIFO            = 32'sd5
) (
    input  logic                           i_aclk,
    input  logic                           i_aresetn,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                           s_axis_tlast,
    input  logic [C_AXIS_USER_WIDTH-1:0]   s_axis_tuser,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                           m_axis_tlast,
    output logic [C_AXIS_USER_WIDTH-1:0]   m_axis_tuser,
    output logic                           o_overflow
);

    localparam int DW = C_AXIS_DATA_WIDTH;
    localparam int KW = C_AXIS_DATA_WIDTH / 32'sd8;
    localparam int UW = C_AXIS_USER_WIDTH;
    localparam int PW = ptr_width(LGFIFO);
    localparam int MW = DW + KW + 32'sd1 + UW;

    localparam logic [PW-1:0] DEPTH_C = {1'b1, {LGFIFO{1'b0}}};
    localparam logic [PW-1:0] ONE_C   = {{LGFIFO{1'b0}}, 1'b1};

    wr_state_e     state_r, state_s;
    logic [PW-1:0] wr_addr_r, wr_addr_s;
    logic [PW-1:0] commit_addr_r, commit_addr_s;
    logic [PW-1:0] rd_addr_r, rd_addr_s;
    logic          s_tready_r, s_tready_s;
    logic          m_tvalid_r, m_tvalid_s;
    logic          overflow_r, overflow_s;

    logic          full_s;
    logic          readable_s;
    logic          s_hs_s;
    logic          we_s;
    logic          re_s;
    logic          drop_beat_s;
    logic [MW-1:0] wdata_s;
    logic [MW-1:0] rdata_s;

`ifdef AXIS_PKT_FIFO_DROP_EN
    assign drop_beat_s = s_axis_tlast && s_axis_tuser[0];
`else
    assign drop_beat_s = 1'b0;
`endif

    assign wdata_s = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    // Pointer, write-state and output-stage next-state logic
    always_comb begin
        wr_addr_s     = wr_addr_r;
        commit_addr_s = commit_addr_r;
        rd_addr_s     = rd_addr_r;
        state_s       = state_r;
        overflow_s    = 1'b0;
        we_s          = 1'b0;
        m_tvalid_s    = m_tvalid_r;

        // Occupancy tests use the pointers as they stand before this cycle's updates
        full_s     = ((wr_addr_r - rd_addr_r) == DEPTH_C);
        readable_s = (rd_addr_r != commit_addr_r);
        s_hs_s     = s_axis_tvalid && s_tready_r;
        re_s       = readable_s && (!m_tvalid_r || m_axis_tready);

        if (re_s) begin
            rd_addr_s  = rd_addr_r + ONE_C;
            m_tvalid_s = 1'b1;
        end else if (m_axis_tready) begin
            m_tvalid_s = 1'b0;
        end else begin
            m_tvalid_s = m_tvalid_r;
        end

        case (state_r)
            WR_FILL: begin
                if (s_hs_s) begin
                    if (drop_beat_s) begin
                        // Rewind over the flagged packet; nothing is committed
                        wr_addr_s = commit_addr_r;
                    end else begin
                        we_s      = 1'b1;
                        wr_addr_s = wr_addr_r + ONE_C;
                        if (s_axis_tlast) begin
                            commit_addr_s = wr_addr_r + ONE_C;
                        end else begin
                            commit_addr_s = commit_addr_r;
                        end
                    end
                end else if (full_s && (commit_addr_r == rd_addr_r)) begin
                    // The partial packet alone fills the FIFO: it can never fit
                    state_s   = WR_DROP;
                    wr_addr_s = commit_addr_r;
                end else begin
                    state_s = WR_FILL;
                end
            end
            WR_DROP: begin
                if (s_hs_s && s_axis_tlast) begin
                    state_s    = WR_FILL;
                    overflow_s = 1'b1;
                end else begin
                    state_s = WR_DROP;
                end
            end
            default: begin
                state_s   = WR_FILL;
                wr_addr_s = commit_addr_r;
            end
        endcase

        s_tready_s = (state_s == WR_DROP) || ((wr_addr_s - rd_addr_s) != DEPTH_C);
    end

    // Pointer, state and handshake registers
    always_ff @(posedge i_aclk) begin
        if (!i_aresetn) begin
            state_r       <= WR_FILL;
            wr_addr_r     <= {PW{1'b0}};
            commit_addr_r <= {PW{1'b0}};
            rd_addr_r     <= {PW{1'b0}};
            s_tready_r    <= 1'b0;
            m_tvalid_r    <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            state_r       <= state_s;
            wr_addr_r     <= wr_addr_s;
            commit_addr_r <= commit_addr_s;
            rd_addr_r     <= rd_addr_s;
            s_tready_r    <= s_tready_s;
            m_tvalid_r    <= m_tvalid_s;
            overflow_r    <= overflow_s;
        end
    end

    axis_pkt_fifo_mem #(
        .AW (LGFIFO),
        .W  (MW)
    ) u_mem (
        .i_aclk    (i_aclk),
        .i_aresetn (i_aresetn),
        .wr_en     (we_s),
        .wr_addr   (wr_addr_r[LGFIFO-1:0]),
        .wr_data   (wdata_s),
        .rd_en     (re_s),
        .rd_addr   (rd_addr_r[LGFIFO-1:0]),
        .rd_data   (rdata_s)
    );

    assign s_axis_tready = s_tready_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tdata  = rdata_s[DW-1:0];
    assign m_axis_tkeep  = rdata_s[DW+KW-1:DW];
    assign m_axis_tlast  = rdata_s[DW+KW];
    assign m_axis_tuser  = rdata_s[MW-1:DW+KW+1];
    assign o_overflow    = overflow_r;

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo (depth 4), checked every cycle against a
// queue-based packet model plus literal expectations for each scenario.
module tb_axis_pkt_fifo;

    localparam int DEPTH = 4;
`ifdef AXIS_PKT_FIFO_DROP_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        u;
        logic        l;
        logic [3:0]  k;
        logic [31:0] d;
    } beat_t;

    logic        i_aclk = 1'b0;
    logic        i_aresetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = 32'h0;
    logic [3:0]  s_axis_tkeep = 4'h0;
    logic        s_axis_tlast = 1'b0;
    logic [0:0]  s_axis_tuser = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic        m_axis_tlast;
    logic [0:0]  m_axis_tuser;
    logic        o_overflow;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    beat_t cq[$];
    beat_t pq[$];
    beat_t out_b = '0;
    bit    out_v = 1'b0;
    bit    drop_m = 1'b0;
    bit    ovf_e = 1'b0;
    bit    trdy_e = 1'b0;
    bit    model_live = 1'b0;

    // observation
    beat_t rx_q[$];
    int    valid_cnt = 0;
    int    ovf_cnt = 0;

    axis_pkt_fifo #(
        .C_AXIS_DATA_WIDTH (32),
        .C_AXIS_USER_WIDTH (1),
        .LGFIFO            (2)
    ) dut (
        .i_aclk        (i_aclk),
        .i_aresetn     (i_aresetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .o_overflow    (o_overflow)
    );

    // Clock
    always #5 i_aclk = ~i_aclk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge i_aclk);
            #1;
        end
    endtask

    // Present one beat and hold it until the DUT takes it (bounded)
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int w;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        w = 0;
        while (s_axis_tready !== 1'b1 && w < 40) begin
            tick(1);
            w++;
        end
        if (w >= 40) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout: ready low 40 cycles for data %0h, expected ready", d);
        end
        tick(1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic wait_rx(input string nm, input int n);
        int w;
        w = 0;
        while (rx_q.size() < n && w < 40) begin
            tick(1);
            w++;
        end
        chk(nm, rx_q.size(), n);
    endtask

    // Packet-level reference model, advanced on every rising edge
    initial begin
        beat_t in_b;
        bit    hs;
        int    occ;
        int    cq0;
        forever begin
            @(posedge i_aclk);
            if (!i_aresetn) begin
                cq.delete();
                pq.delete();
                drop_m = 1'b0;
                out_v = 1'b0;
                out_b = '0;
                ovf_e = 1'b0;
                trdy_e = 1'b0;
                model_live = 1'b1;
            end else begin
                in_b = {s_axis_tuser[0], s_axis_tlast, s_axis_tkeep, s_axis_tdata};
                hs = s_axis_tvalid && trdy_e;
                cq0 = cq.size();
                occ = cq.size() + pq.size();
                if (cq0 > 0 && (!out_v || m_axis_tready)) begin
                    out_b = cq.pop_front();
                    out_v = 1'b1;
                end else if (m_axis_tready) begin
                    out_v = 1'b0;
                end
                ovf_e = 1'b0;
                if (drop_m) begin
                    if (hs && in_b.l) begin
                        drop_m = 1'b0;
                        ovf_e = 1'b1;
                    end
                end else if (hs) begin
                    if (DROP_EN && in_b.l && in_b.u) begin
                        pq.delete();
                    end else begin
                        pq.push_back(in_b);
                        if (in_b.l) begin
                            while (pq.size() > 0) cq.push_back(pq.pop_front());
                        end
                    end
                end else if (occ == DEPTH && cq0 == 0) begin
                    drop_m = 1'b1;
                    pq.delete();
                end
                trdy_e = drop_m || ((cq.size() + pq.size()) != DEPTH);
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model, on the falling edge
    initial begin
        forever begin
            @(negedge i_aclk);
            if (model_live) begin
                chk("s_tready", s_axis_tready, trdy_e);
                chk("m_tvalid", m_axis_tvalid, out_v);
                chk("overflow", o_overflow, ovf_e);
                if (out_v && m_axis_tvalid) begin
                    chk("m_beat", {m_axis_tuser[0], m_axis_tlast, m_axis_tkeep, m_axis_tdata}, out_b);
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    rx_q.push_back({m_axis_tuser[0], m_axis_tlast, m_axis_tkeep, m_axis_tdata});
                end
                if (m_axis_tvalid) valid_cnt++;
                if (o_overflow) ovf_cnt++;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1, "watchdog");
    end

    // Directed stimulus with literal expectations
    initial begin
        int v0;
        int o0;
        int ucnt;

        // reset state
        tick(3);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_mvalid", m_axis_tvalid, 1'b0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_mdata", m_axis_tdata, 32'h0);
        i_aresetn = 1'b1;
        tick(1);
        chk("post_rst_tready", s_axis_tready, 1'b1);

        // 3-beat packet, latency 2 cycles after TLAST
        m_axis_tready = 1'b1;
        rx_q.delete();
        send(32'hA000_0001, 4'hF, 1'b0, 1'b0);
        send(32'hA000_0002, 4'hF, 1'b0, 1'b0);
        send(32'hA000_0003, 4'h3, 1'b1, 1'b0);
        chk("t1_n1_mvalid", m_axis_tvalid, 1'b0);
        tick(1);
        chk("t1_b0_valid", m_axis_tvalid, 1'b1);
        chk("t1_b0_data", m_axis_tdata, 32'hA000_0001);
        tick(1);
        chk("t1_b1_data", {m_axis_tlast, m_axis_tdata}, {1'b0, 32'hA000_0002});
        tick(1);
        chk("t1_b2_data", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, {1'b1, 4'h3, 32'hA000_0003});
        tick(1);
        chk("t1_end_mvalid", m_axis_tvalid, 1'b0);
        chk("t1_count", rx_q.size(), 3);

        // fill to depth with M stalled
        rx_q.delete();
        m_axis_tready = 1'b0;
        send(32'hB000_0001, 4'hF, 1'b0, 1'b0);
        send(32'hB000_0002, 4'hF, 1'b0, 1'b0);
        send(32'hB000_0003, 4'hF, 1'b0, 1'b0);
        send(32'hB000_0004, 4'hF, 1'b1, 1'b0);
        chk("t2_full_tready", s_axis_tready, 1'b0);
        m_axis_tready = 1'b1;
        wait_rx("t2_count", 4);
        if (rx_q.size() >= 4) begin
            chk("t2_first", rx_q[0].d, 32'hB000_0001);
            chk("t2_last", {rx_q[3].l, rx_q[3].d}, {1'b1, 32'hB000_0004});
        end
        tick(2);
        chk("t2_tready_back", s_axis_tready, 1'b1);

        // oversize packet dropped, then a small packet passes
        rx_q.delete();
        v0 = valid_cnt;
        o0 = ovf_cnt;
        send(32'hC000_0001, 4'hF, 1'b0, 1'b0);
        send(32'hC000_0002, 4'hF, 1'b0, 1'b0);
        send(32'hC000_0003, 4'hF, 1'b0, 1'b0);
        send(32'hC000_0004, 4'hF, 1'b0, 1'b0);
        chk("t3_full_tready", s_axis_tready, 1'b0);
        send(32'hC000_0005, 4'hF, 1'b0, 1'b0);
        send(32'hC000_0006, 4'hF, 1'b1, 1'b0);
        chk("t3_ovf_pulse", o_overflow, 1'b1);
        tick(1);
        chk("t3_ovf_clear", o_overflow, 1'b0);
        chk("t3_no_mvalid", valid_cnt - v0, 0);
        chk("t3_ovf_count", ovf_cnt - o0, 1);
        send(32'hD000_0001, 4'hF, 1'b0, 1'b0);
        send(32'hD000_0002, 4'h1, 1'b1, 1'b0);
        wait_rx("t3_small_count", 2);
        if (rx_q.size() >= 2) begin
            chk("t3_d1", rx_q[0].d, 32'hD000_0001);
            chk("t3_d2", {rx_q[1].l, rx_q[1].k, rx_q[1].d}, {1'b1, 4'h1, 32'hD000_0002});
        end

        // M stall mid-packet
        rx_q.delete();
        send(32'hE000_0001, 4'hF, 1'b0, 1'b0);
        send(32'hE000_0002, 4'hF, 1'b0, 1'b0);
        send(32'hE000_0003, 4'hF, 1'b0, 1'b0);
        send(32'hE000_0004, 4'hF, 1'b1, 1'b0);
        tick(1);
        chk("t4_e1", m_axis_tdata, 32'hE000_0001);
        tick(1);
        chk("t4_e2", m_axis_tdata, 32'hE000_0002);
        m_axis_tready = 1'b0;
        tick(1);
        chk("t4_stall1", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'hE000_0002});
        tick(1);
        chk("t4_stall2", {m_axis_tvalid, m_axis_tdata}, {1'b1, 32'hE000_0002});
        m_axis_tready = 1'b1;
        tick(1);
        chk("t4_e3", m_axis_tdata, 32'hE000_0003);
        wait_rx("t4_count", 4);
        if (rx_q.size() >= 4) begin
            chk("t4_rx1", rx_q[1].d, 32'hE000_0002);
            chk("t4_rx2", rx_q[2].d, 32'hE000_0003);
            chk("t4_rx3", rx_q[3].d, 32'hE000_0004);
        end

        // reset with two committed packets and a partial one
        rx_q.delete();
        m_axis_tready = 1'b0;
        send(32'hF000_0001, 4'hF, 1'b1, 1'b0);
        send(32'h6000_0001, 4'hF, 1'b0, 1'b0);
        send(32'h6000_0002, 4'hF, 1'b1, 1'b0);
        send(32'h7000_0001, 4'hF, 1'b0, 1'b0);
        chk("t5_pre_mvalid", m_axis_tvalid, 1'b1);
        i_aresetn = 1'b0;
        tick(1);
        chk("t5_rst_mvalid", m_axis_tvalid, 1'b0);
        chk("t5_rst_tready", s_axis_tready, 1'b0);
        tick(1);
        i_aresetn = 1'b1;
        tick(1);
        chk("t5_post_tready", s_axis_tready, 1'b1);
        chk("t5_post_mvalid", m_axis_tvalid, 1'b0);
        m_axis_tready = 1'b1;
        rx_q.delete();
        send(32'h8000_0001, 4'hF, 1'b0, 1'b0);
        send(32'h8000_0002, 4'hF, 1'b1, 1'b0);
        wait_rx("t5_count", 2);
        tick(3);
        chk("t5_exact_count", rx_q.size(), 2);
        if (rx_q.size() >= 2) begin
            chk("t5_i1", rx_q[0].d, 32'h8000_0001);
            chk("t5_i2", rx_q[1].d, 32'h8000_0002);
        end

        // error-flagged packet
        rx_q.delete();
        o0 = ovf_cnt;
        send(32'h9000_0001, 4'hF, 1'b0, 1'b0);
        send(32'h9000_0002, 4'hF, 1'b0, 1'b0);
        send(32'h9000_0003, 4'hF, 1'b1, 1'b1);
        tick(6);
        chk("t6_count", rx_q.size(), DROP_EN ? 0 : 3);
        ucnt = 0;
        foreach (rx_q[i]) if (rx_q[i].u && rx_q[i].l) ucnt++;
        chk("t6_tuser_last", ucnt, DROP_EN ? 0 : 1);
        chk("t6_no_ovf", ovf_cnt - o0, 0);
        rx_q.delete();
        send(32'h9100_0001, 4'hF, 1'b1, 1'b0);
        wait_rx("t6_next_count", 1);
        if (rx_q.size() >= 1) begin
            chk("t6_next_data", rx_q[0].d, 32'h9100_0001);
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
